// File: rtl/noc_axi_id_remap.sv
// noc_axi_id_remap: compresses a wide tile-side AXI ID into a narrow NoC ID
// and restores it on responses. Handles one request/response channel pair.
// Optional stall statistics counter is enabled by defining NOC_ID_REMAP_STATS_EN.
module noc_axi_id_remap #(
  parameter int unsigned SLV_ID_W        = 6,
  parameter int unsigned MST_ID_W        = 4,
  parameter int unsigned MAX_TXNS_PER_ID = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                slv_req_valid_i,
  output logic                slv_req_ready_o,
  input  logic [SLV_ID_W-1:0] slv_req_id_i,
  output logic                mst_req_valid_o,
  input  logic                mst_req_ready_i,
  output logic [MST_ID_W-1:0] mst_req_id_o,
  input  logic                mst_rsp_valid_i,
  output logic                mst_rsp_ready_o,
  input  logic [MST_ID_W-1:0] mst_rsp_id_i,
  input  logic                mst_rsp_last_i,
  output logic                slv_rsp_valid_o,
  input  logic                slv_rsp_ready_i,
  output logic [SLV_ID_W-1:0] slv_rsp_id_o,
  output logic                idle_o,
  output logic [31:0]         stall_cnt_o
);

  localparam int unsigned NUM_ENT = 1 << MST_ID_W;
  localparam int unsigned CNT_W   = $clog2(MAX_TXNS_PER_ID + 1);

  // Remap table
  logic [NUM_ENT-1:0]  used_q;
  logic [SLV_ID_W-1:0] slv_id_q [NUM_ENT];
  logic [CNT_W-1:0]    cnt_q    [NUM_ENT];

  // Request output register and registered idle flag
  logic                out_valid_q;
  logic [MST_ID_W-1:0] out_id_q;
  logic                idle_q;

  // Lookup results
  logic                hit;
  logic [MST_ID_W-1:0] hit_idx;
  logic                free;
  logic [MST_ID_W-1:0] free_idx;
  logic                can_accept;
  logic [MST_ID_W-1:0] alloc_idx;
  logic                req_hs;
  logic                rsp_dec;
  logic [NUM_ENT-1:0]  inc_vec;
  logic [NUM_ENT-1:0]  dec_vec;
  logic                any_cnt;

  // Find matching used entry and lowest free entry (downward scan so lowest index wins)
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int e = NUM_ENT - 1; e >= 0; e--) begin
      if (used_q[e] && (slv_id_q[e] == slv_req_id_i)) begin
        hit     = 1'b1;
        hit_idx = MST_ID_W'(e);
      end
      if (!used_q[e]) begin
        free     = 1'b1;
        free_idx = MST_ID_W'(e);
      end
    end
  end

  // Admission: a hit may only reuse its entry while below the outstanding limit
  always_comb begin
    can_accept = 1'b0;
    alloc_idx  = free_idx;
    if (hit) begin
      can_accept = (cnt_q[hit_idx] < CNT_W'(MAX_TXNS_PER_ID));
      alloc_idx  = hit_idx;
    end else begin
      can_accept = free;
    end
  end

  assign slv_req_ready_o = can_accept && (!out_valid_q || mst_req_ready_i);
  assign req_hs          = slv_req_valid_i && slv_req_ready_o;
  assign rsp_dec         = mst_rsp_valid_i && slv_rsp_ready_i && mst_rsp_last_i;

  // Per-entry increment/decrement strobes; a decrement at cnt==0 is dropped (saturate)
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    any_cnt = 1'b0;
    for (int e = 0; e < NUM_ENT; e++) begin
      inc_vec[e] = req_hs && (alloc_idx == MST_ID_W'(e));
      dec_vec[e] = rsp_dec && (mst_rsp_id_i == MST_ID_W'(e)) && (cnt_q[e] != '0);
      any_cnt    = any_cnt || (cnt_q[e] != '0);
    end
  end

  // Table update; simultaneous inc and dec on one entry leaves it unchanged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      used_q <= '0;
      for (int e = 0; e < NUM_ENT; e++) begin
        slv_id_q[e] <= '0;
        cnt_q[e]    <= '0;
      end
    end else begin
      for (int e = 0; e < NUM_ENT; e++) begin
        if (inc_vec[e] && !dec_vec[e]) begin
          used_q[e]   <= 1'b1;
          slv_id_q[e] <= slv_req_id_i;
          cnt_q[e]    <= cnt_q[e] + CNT_W'(1);
        end else if (dec_vec[e] && !inc_vec[e]) begin
          cnt_q[e] <= cnt_q[e] - CNT_W'(1);
          if (cnt_q[e] == CNT_W'(1)) begin
            used_q[e] <= 1'b0;
          end
        end
      end
    end
  end

  // Request output register: loads on handshake, drains when the NoC accepts
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
    end else if (req_hs) begin
      out_valid_q <= 1'b1;
      out_id_q    <= alloc_idx;
    end else if (mst_req_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  // Idle flag lags table state by one cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_q <= 1'b1;
    end else begin
      idle_q <= !out_valid_q && !any_cnt;
    end
  end

  assign mst_req_valid_o = out_valid_q;
  assign mst_req_id_o    = out_id_q;
  assign idle_o          = idle_q;

  // Response path is a combinational pass-through with ID restore
  assign slv_rsp_valid_o = mst_rsp_valid_i;
  assign mst_rsp_ready_o = slv_rsp_ready_i;
  assign slv_rsp_id_o    = slv_id_q[mst_rsp_id_i];

`ifdef NOC_ID_REMAP_STATS_EN
  logic [31:0] stall_q;

  // Count cycles where a request is presented but the table cannot take it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (slv_req_valid_i && !can_accept && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_noc_axi_id_remap.sv
// Testbench for noc_axi_id_remap: directed scenarios plus randomized traffic,
// every cycle checked against a transaction-level reference model.
module tb_noc_axi_id_remap;

  localparam int unsigned SW   = 6;
  localparam int unsigned MW   = 4;
  localparam int unsigned MAXT = 8;
  localparam int unsigned NE   = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          slv_req_valid_i;
  logic          slv_req_ready_o;
  logic [SW-1:0] slv_req_id_i;
  logic          mst_req_valid_o;
  logic          mst_req_ready_i;
  logic [MW-1:0] mst_req_id_o;
  logic          mst_rsp_valid_i;
  logic          mst_rsp_ready_o;
  logic [MW-1:0] mst_rsp_id_i;
  logic          mst_rsp_last_i;
  logic          slv_rsp_valid_o;
  logic          slv_rsp_ready_i;
  logic [SW-1:0] slv_rsp_id_o;
  logic          idle_o;
  logic [31:0]   stall_cnt_o;

  always #5 clk_i = ~clk_i;

  noc_axi_id_remap #(
    .SLV_ID_W(SW), .MST_ID_W(MW), .MAX_TXNS_PER_ID(MAXT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slv_req_valid_i(slv_req_valid_i), .slv_req_ready_o(slv_req_ready_o),
    .slv_req_id_i(slv_req_id_i),
    .mst_req_valid_o(mst_req_valid_o), .mst_req_ready_i(mst_req_ready_i),
    .mst_req_id_o(mst_req_id_o),
    .mst_rsp_valid_i(mst_rsp_valid_i), .mst_rsp_ready_o(mst_rsp_ready_o),
    .mst_rsp_id_i(mst_rsp_id_i), .mst_rsp_last_i(mst_rsp_last_i),
    .slv_rsp_valid_o(slv_rsp_valid_o), .slv_rsp_ready_i(slv_rsp_ready_i),
    .slv_rsp_id_o(slv_rsp_id_o),
    .idle_o(idle_o), .stall_cnt_o(stall_cnt_o)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: outstanding count and owner per NoC ID, plus the request slot
  int     m_cnt [NE];
  int     m_sid [NE];
  bit     m_wr  [NE];
  bit     m_ov;
  int     m_oid;
  bit     m_idle;
  longint m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_cnt[i] = 0;
      m_sid[i] = 0;
      m_wr[i]  = 1'b0;
    end
    m_ov    = 1'b0;
    m_oid   = 0;
    m_idle  = 1'b1;
    m_stall = 0;
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, advance model
  task automatic step(input bit rv, input int rid, input bit mr,
                      input bit pv, input int pid, input bit pl, input bit sr);
    int hit = -1;
    int fr  = -1;
    int idx = 0;
    bit can;
    bit rdy;
    bit all_zero = 1'b1;
    bit dec;
    slv_req_valid_i = rv;
    slv_req_id_i    = SW'(rid);
    mst_req_ready_i = mr;
    mst_rsp_valid_i = pv;
    mst_rsp_id_i    = MW'(pid);
    mst_rsp_last_i  = pl;
    slv_rsp_ready_i = sr;
    #2;
    for (int i = 0; i < NE; i++) begin
      if (m_cnt[i] > 0 && m_sid[i] == rid && hit < 0) hit = i;
      if (m_cnt[i] == 0 && fr < 0) fr = i;
      if (m_cnt[i] != 0) all_zero = 1'b0;
    end
    if (hit >= 0) begin
      can = (m_cnt[hit] < int'(MAXT));
      idx = hit;
    end else begin
      can = (fr >= 0);
      idx = fr;
    end
    rdy = can && (!m_ov || mr);
    chk("slv_req_ready", 32'(slv_req_ready_o), 32'(rdy));
    chk("mst_req_valid", 32'(mst_req_valid_o), 32'(m_ov));
    chk("mst_req_id", 32'(mst_req_id_o), 32'(m_oid));
    chk("slv_rsp_valid", 32'(slv_rsp_valid_o), 32'(pv));
    chk("mst_rsp_ready", 32'(mst_rsp_ready_o), 32'(sr));
    if (m_wr[pid]) chk("slv_rsp_id", 32'(slv_rsp_id_o), 32'(m_sid[pid]));
    chk("idle", 32'(idle_o), 32'(m_idle));
`ifdef NOC_ID_REMAP_STATS_EN
    chk("stall_cnt", stall_cnt_o, 32'(m_stall));
`else
    chk("stall_cnt", stall_cnt_o, 32'd0);
`endif
    m_idle = !m_ov && all_zero;
    if (rv && !can && m_stall < 64'hFFFF_FFFF) m_stall++;
    dec = pv && sr && pl && (m_cnt[pid] > 0);
    if (dec) m_cnt[pid]--;
    if (rv && rdy) begin
      m_cnt[idx]++;
      m_sid[idx] = rid;
      m_wr[idx]  = 1'b1;
      m_ov       = 1'b1;
      m_oid      = idx;
    end else if (mr) begin
      m_ov = 1'b0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic req(input int rid);
    step(1'b1, rid, 1'b1, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic rsp(input int pid, input bit last);
    step(1'b0, 0, 1'b1, 1'b1, pid, last, 1'b1);
  endtask

  task automatic drain_all();
    for (int i = 0; i < NE; i++) begin
      while (m_cnt[i] > 0) rsp(i, 1'b1);
    end
    idle_step();
    idle_step();
  endtask

  initial begin
    longint s0;
    int     pid;
    int     used_list [$];

    slv_req_valid_i = 1'b0;
    slv_req_id_i    = '0;
    mst_req_ready_i = 1'b0;
    mst_rsp_valid_i = 1'b0;
    mst_rsp_id_i    = '0;
    mst_rsp_last_i  = 1'b0;
    slv_rsp_ready_i = 1'b0;
    rst_i           = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state
    idle_step();
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_mst_valid", 32'(mst_req_valid_o), 32'd0);
    chk("rst_mst_id", 32'(mst_req_id_o), 32'd0);
    chk("rst_stall", stall_cnt_o, 32'd0);

    // Single write: ID 0x2A -> NoC ID 0, restored on B, idle one cycle later
    req(6'h2A);
    chk("t1_valid", 32'(mst_req_valid_o), 32'd1);
    chk("t1_id", 32'(mst_req_id_o), 32'd0);
    idle_step();
    rsp(0, 1'b1);
    chk("t1_idle_lag", 32'(idle_o), 32'd0);
    idle_step();
    chk("t1_idle", 32'(idle_o), 32'd1);

    // Back-to-back distinct IDs map to 0,1,2 at full throughput
    req(1);
    chk("t2_id0", 32'(mst_req_id_o), 32'd0);
    req(2);
    chk("t2_id1", 32'(mst_req_id_o), 32'd1);
    req(3);
    chk("t2_id2", 32'(mst_req_id_o), 32'd2);
    drain_all();

    // Per-ID depth limit: 9th request with same ID stalls until one response
    repeat (8) req(5);
    chk("t3_id", 32'(mst_req_id_o), 32'd0);
    step(1'b1, 5, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    chk("t3_stalled", 32'(mst_req_valid_o), 32'd0);
    step(1'b1, 5, 1'b1, 1'b1, 0, 1'b1, 1'b1);
    req(5);
    chk("t3_accepted", 32'(mst_req_valid_o), 32'd1);
    chk("t3_id_again", 32'(mst_req_id_o), 32'd0);
    drain_all();

    // Table full: 17th distinct ID stalls, takes NoC ID 7 once it frees
    for (int k = 0; k < 16; k++) req(8'h10 + k);
    chk("t4_last_id", 32'(mst_req_id_o), 32'd15);
    step(1'b1, 6'h20, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 6'h20, 1'b1, 1'b1, 7, 1'b1, 1'b1);
    req(6'h20);
    chk("t4_id7", 32'(mst_req_id_o), 32'd7);

    // Back-pressure: request ID held stable, even when an entry frees meanwhile
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 6'h10, 1'b0, (k == 2), 3, 1'b1, 1'b1);
      chk("t5_hold_id", 32'(mst_req_id_o), 32'd7);
      chk("t5_hold_valid", 32'(mst_req_valid_o), 32'd1);
    end
    req(6'h10);
    chk("t5_hit_id", 32'(mst_req_id_o), 32'd0);

    // R burst: only the last beat releases the entry
    req(6'h33);
    chk("t6_id3", 32'(mst_req_id_o), 32'd3);
    idle_step();
    repeat (3) rsp(3, 1'b0);
    step(1'b1, 6'h34, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    chk("t6_still_full", 32'(mst_req_valid_o), 32'd0);
    rsp(3, 1'b1);
    req(6'h34);
    chk("t6_reuse3", 32'(mst_req_id_o), 32'd3);

    // Ten stall cycles on a full table
    s0 = m_stall;
    repeat (10) step(1'b1, 6'h35, 1'b1, 1'b0, 0, 1'b0, 1'b1);
`ifdef NOC_ID_REMAP_STATS_EN
    chk("t7_stall10", stall_cnt_o, 32'(s0 + 10));
`else
    chk("t7_stall_off", stall_cnt_o, 32'(s0 - s0));
`endif

    // Protocol error: response to an empty entry saturates at zero
    drain_all();
    rsp(9, 1'b1);
    idle_step();
    chk("t8_idle_after_err", 32'(idle_o), 32'd1);
    req(6'h3F);
    chk("t8_id0", 32'(mst_req_id_o), 32'd0);
    drain_all();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      used_list.delete();
      for (int i = 0; i < NE; i++) if (m_cnt[i] > 0) used_list.push_back(i);
      if (used_list.size() > 0 && $urandom_range(0, 9) < 9)
        pid = used_list[$urandom_range(0, used_list.size() - 1)];
      else
        pid = int'($urandom_range(0, NE - 1));
      step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 19)),
           bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
           pid, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0));
    end

    // Mid-operation reset drops all state
    req(6'h11);
    req(6'h12);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
    idle_step();
    chk("rst2_idle", 32'(idle_o), 32'd1);
    chk("rst2_valid", 32'(mst_req_valid_o), 32'd0);
    chk("rst2_stall", stall_cnt_o, 32'd0);
    req(6'h12);
    chk("rst2_id0", 32'(mst_req_id_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/noc_axi_id_remap.md
Name: noc_axi_id_remap

Overview:
- Parametrised AXI ID remapper for the tile-to-NoC boundary.
- Compresses a wide slave-side ID space into the narrow NoC ID space (AXI_NOC_ID_W) and restores the original ID on responses.
- One instance handles one request/response channel pair (AW/B or AR/R); a tile uses two instances.
- Generalises the fixed 4-bit NoC ID: both widths and the per-ID outstanding depth are parameters, and ordering is preserved by tracking outstanding transactions.

Parameters:
- SLV_ID_W, 6, slave-side (tile-internal) ID width.
- MST_ID_W, 4, NoC-side ID width; table has 2**MST_ID_W entries.
- MAX_TXNS_PER_ID, 8, max outstanding transactions per mapped ID; counter width is $clog2(MAX_TXNS_PER_ID+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- slv_req_valid_i  in  1  request valid from tile
- slv_req_ready_o  out  1  request ready to tile
- slv_req_id_i  in  SLV_ID_W  request ID from tile
- mst_req_valid_o  out  1  request valid to NoC
- mst_req_ready_i  in  1  request ready from NoC
- mst_req_id_o  out  MST_ID_W  remapped request ID
- mst_rsp_valid_i  in  1  response valid from NoC
- mst_rsp_ready_o  out  1  response ready to NoC
- mst_rsp_id_i  in  MST_ID_W  response ID from NoC
- mst_rsp_last_i  in  1  final beat of the response (tie 1 for B)
- slv_rsp_valid_o  out  1  response valid to tile
- slv_rsp_ready_i  in  1  response ready from tile
- slv_rsp_id_o  out  SLV_ID_W  restored response ID
- idle_o  out  1  no outstanding transactions and output register empty
- stall_cnt_o  out  32  stall cycle counter (see Optional Feature)

Behaviour:
- Table: 2**MST_ID_W entries, each holding {used, slv_id, cnt}.
- Reset: all entries unused with cnt=0; output register empty; mst_req_valid_o=0; mst_req_id_o=0; idle_o=1; stall_cnt_o=0.
  - Reset mid-operation drops all state; in-flight responses after reset are the system's responsibility.
- Request path:
  - A single output register gives 1-cycle latency from slave handshake to mst_req_valid_o.
  - Full throughput: the register accepts a new request when it is empty, or when it is full and mst_req_ready_i=1 in the same cycle.
  - mst_req_id_o is held stable while mst_req_valid_o=1 and mst_req_ready_i=0, as AXI requires.
- Assignment, evaluated combinationally on slv_req_id_i:
  - Hit: a used entry has slv_id==slv_req_id_i.
    - If its cnt<MAX_TXNS_PER_ID, reuse that index.
    - Otherwise stall.
  - Miss with a free entry: take the lowest-index unused entry.
  - Miss with no free entry: stall.
  - can_accept = hit-with-room OR miss-with-free.
  - slv_req_ready_o = can_accept AND (register empty OR mst_req_ready_i).
  - slv_req_ready_o is independent of slv_req_valid_i.
- Table update on slave request handshake: set used, write slv_id, cnt+1.
- Response path:
  - Combinational pass-through: slv_rsp_valid_o = mst_rsp_valid_i, mst_rsp_ready_o = slv_rsp_ready_i.
  - slv_rsp_id_o = table[mst_rsp_id_i].slv_id.
- On a response handshake with mst_rsp_last_i=1: cnt-1 on entry mst_rsp_id_i; when cnt reaches 0, clear used.
  - A freed entry becomes allocatable on the next cycle, not the same cycle.
- Simultaneous increment and decrement on the same entry in one cycle: cnt unchanged and entry stays used.
- Response to an entry with cnt=0 is a protocol error:
  - Forwarded with slv_id as stored.
  - cnt saturates at 0 and does not wrap.
- idle_o = register empty AND all cnt==0, registered (one cycle behind table state).
- Ordering: same slv ID always maps to the same NoC ID while outstanding, so AXI same-ID ordering is preserved end to end.

Optional Feature:
- Macro: NOC_ID_REMAP_STATS_EN.
- Defined:
  - stall_cnt_o increments on every cycle with slv_req_valid_i=1 AND can_accept=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst_i.
- Undefined: stall_cnt_o is tied to 0 and no counter logic is generated.

Test Plan:
- Single write, slv ID 0x2A: NoC request appears next cycle with id=0. B with id=0, last=1 returns slv_rsp_id_o=0x2A. idle_o returns to 1 one cycle after the B handshake.
- IDs 0x01,0x02,0x03 back-to-back with mst_req_ready_i=1: NoC IDs 0,1,2 on consecutive cycles; slv_req_ready_o stays 1 throughout.
- Nine requests with slv ID 0x05 and no responses: first 8 map to NoC ID 0; 9th stalls with slv_req_ready_o=0. After one response on ID 0, the 9th is accepted the following cycle.
- 16 distinct slv IDs outstanding, then a 17th distinct ID: stall. Freeing NoC ID 7 lets the 17th take ID 7 on the next cycle.
- mst_req_ready_i=0 for 5 cycles with valid held: mst_req_id_o and mst_req_valid_o stay constant. A response freeing another entry during the stall does not change mst_req_id_o.
- R burst of 4 beats on ID 3 (last only on beat 4): cnt decrements once, after beat 4. With NOC_ID_REMAP_STATS_EN, a 10-cycle stall yields stall_cnt_o=10.
